sprite_overlay_mc: RTL and testbench

- Multi-sprite pixel overlay stage that sits between the background/scroll renderer and the VGA adapter write port.
- For each background pixel it composites up to NUM_SPRITES rectangular solid-colour sprites using fixed priority.
- Reports sprite-vs-background and sprite-vs-sprite collisions.
- Sprite positions are double-buffered so that a frame is never drawn with torn coordinates.

---
 rtl/sprite_overlay_mc.sv | 145 ++++++++++++++
 tb/tb_sprite_overlay_mc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_overlay_mc.sv
`default_nettype none
// ============================================================================
// Module      : sprite_overlay_mc
// Description : Two-stage multi-sprite overlay with fixed priority, double-
//               buffered sprite positions and sticky collision flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_overlay_mc #(
    parameter int                  NUM_SPRITES = 4,
    parameter int                  COLOUR_W    = 3,
    parameter int                  X_W         = 8,
    parameter int                  Y_W         = 7,
    parameter int                  SPR_W       = 7,
    parameter int                  SPR_H       = 10,
    parameter logic [COLOUR_W-1:0] SKY_COLOUR  = 3'b011
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            frame_start,
    input  logic                            pix_valid,
    input  logic [X_W-1:0]                  x,
    input  logic [Y_W-1:0]                  y,
    input  logic [COLOUR_W-1:0]             in_colour,
    input  logic [NUM_SPRITES*X_W-1:0]      spr_x,
    input  logic [NUM_SPRITES*Y_W-1:0]      spr_y,
    input  logic [NUM_SPRITES*COLOUR_W-1:0] spr_colour,
    input  logic [NUM_SPRITES-1:0]          spr_en,
    output logic                            out_valid,
    output logic [X_W-1:0]                  out_x,
    output logic [Y_W-1:0]                  out_y,
    output logic [COLOUR_W-1:0]             out_colour,
    output logic [NUM_SPRITES-1:0]          hit_bg,
    output logic                            hit_spr,
    output logic                            hit_now
);

    // One bit wider than the coordinate so sprites near the edge clip instead of wrapping.
    localparam logic [X_W:0] c_x_span = (X_W+1)'(SPR_W - 1);
    localparam logic [Y_W:0] c_y_span = (Y_W+1)'(SPR_H - 1);

    logic [X_W-1:0]         r_ax   [NUM_SPRITES];
    logic [Y_W-1:0]         r_ay   [NUM_SPRITES];
    logic [COLOUR_W-1:0]    r_acol [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] r_aen;

    logic                   r_s1_valid;
    logic [X_W-1:0]         r_s1_x;
    logic [Y_W-1:0]         r_s1_y;
    logic [COLOUR_W-1:0]    r_s1_col;
    logic [NUM_SPRITES-1:0] r_s1_inside;

    logic [NUM_SPRITES-1:0] w_inside;
    logic [COLOUR_W-1:0]    w_colour;
    logic                   w_seen;
    logic                   w_multi;
    logic                   w_nonsky;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_aen <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_ax[i]   <= '0;
                r_ay[i]   <= '0;
                r_acol[i] <= '0;
            end
        end else if (frame_start) begin
            r_aen <= spr_en;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_ax[i]   <= spr_x[i*X_W +: X_W];
                r_ay[i]   <= spr_y[i*Y_W +: Y_W];
                r_acol[i] <= spr_colour[i*COLOUR_W +: COLOUR_W];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_inside
            assign w_inside[gi] = r_aen[gi]
                & ({1'b0, x} >= {1'b0, r_ax[gi]}) & ({1'b0, x} <= ({1'b0, r_ax[gi]} + c_x_span))
                & ({1'b0, y} >= {1'b0, r_ay[gi]}) & ({1'b0, y} <= ({1'b0, r_ay[gi]} + c_y_span));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_col    <= '0;
            r_s1_inside <= '0;
        end else begin
            r_s1_valid  <= pix_valid;
            r_s1_x      <= x;
            r_s1_y      <= y;
            r_s1_col    <= in_colour;
            r_s1_inside <= w_inside;
        end
    end

    // Walk from the highest index down so the lowest covering sprite wins.
    always_comb begin
        w_colour = r_s1_col;
        w_seen   = 1'b0;
        w_multi  = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_s1_inside[i]) w_colour = r_acol[i];
        end
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (r_s1_inside[i]) begin
                if (w_seen) w_multi = 1'b1;
                w_seen = 1'b1;
            end
        end
    end

    assign w_nonsky = (r_s1_col != SKY_COLOUR);

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_colour <= SKY_COLOUR;
            hit_now    <= 1'b0;
            hit_bg     <= '0;
            hit_spr    <= 1'b0;
        end else begin
            out_valid  <= r_s1_valid;
            out_x      <= r_s1_x;
            out_y      <= r_s1_y;
            out_colour <= w_colour;
            hit_now    <= r_s1_valid & (|r_s1_inside) & w_nonsky;
            // Clearing takes precedence over any hit arriving on the same edge.
            if (frame_start) begin
                hit_bg  <= '0;
                hit_spr <= 1'b0;
            end else if (r_s1_valid) begin
                hit_bg  <= hit_bg | (r_s1_inside & {NUM_SPRITES{w_nonsky}});
                hit_spr <= hit_spr | w_multi;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_overlay_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_overlay_mc
// Description : Scoreboard bench for sprite_overlay_mc using directed pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_overlay_mc;

    localparam logic [2:0] c_SKY = 3'b011;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        frame_start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  x = '0;
    logic [6:0]  y = '0;
    logic [2:0]  in_colour = c_SKY;
    logic [31:0] spr_x = '0;
    logic [27:0] spr_y = '0;
    logic [11:0] spr_colour = '0;
    logic [3:0]  spr_en = '0;
    logic        out_valid;
    logic [7:0]  out_x;
    logic [6:0]  out_y;
    logic [2:0]  out_colour;
    logic [3:0]  hit_bg;
    logic        hit_spr;
    logic        hit_now;

    sprite_overlay_mc dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .pix_valid(pix_valid), .x(x), .y(y), .in_colour(in_colour),
        .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour), .spr_en(spr_en),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .out_colour(out_colour), .hit_bg(hit_bg), .hit_spr(hit_spr),
        .hit_now(hit_now)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] col;
        logic       hit;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clock) cyc = cyc + 1;

    always @(negedge clock) begin
        exp_t e;
        if (out_valid) begin
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_pixel got x=%0d y=%0d col=%b", out_x, out_y, out_colour);
            end else begin
                e = sb.pop_front();
                if (out_x !== e.x || out_y !== e.y || out_colour !== e.col ||
                    hit_now !== e.hit || cyc != e.cyc + 2) begin
                    errors = errors + 1;
                    $display("FAIL pixel got x=%0d y=%0d col=%b hit=%b cyc=%0d exp x=%0d y=%0d col=%b hit=%b cyc=%0d",
                             out_x, out_y, out_colour, hit_now, cyc, e.x, e.y, e.col, e.hit, e.cyc + 2);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            pix_valid   = 1'b0;
            frame_start = 1'b0;
        end
    endtask

    task automatic pixel(input int px, input int py, input logic [2:0] bg,
                         input logic [2:0] col, input logic hit);
        exp_t e;
        step();
        frame_start = 1'b0;
        pix_valid   = 1'b1;
        x           = 8'(px);
        y           = 7'(py);
        in_colour   = bg;
        e.x = 8'(px); e.y = 7'(py); e.col = col; e.hit = hit; e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic frame();
        idle(2);
        step();
        pix_valid   = 1'b0;
        frame_start = 1'b1;
        idle(2);
    endtask

    task automatic set_spr(input int i, input int sx, input int sy, input logic [2:0] col);
        spr_x[i*8 +: 8]      = 8'(sx);
        spr_y[i*7 +: 7]      = 7'(sy);
        spr_colour[i*3 +: 3] = col;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_colour", 32'(out_colour), 32'(c_SKY));
        check("rst_hits", {hit_bg, hit_spr, hit_now}, 32'd0);
        reset = 1'b0;

        // Empty frame scanned over sky
        spr_en = 4'b0000;
        frame();
        for (int j = 0; j < 10; j++)
            for (int i = 0; i < 10; i++)
                pixel(i, j, c_SKY, c_SKY, 1'b0);
        idle(4);
        check("empty_hits", {hit_bg, hit_spr}, 32'd0);

        // Single sprite edge inclusivity
        set_spr(0, 20, 30, 3'b100);
        spr_en = 4'b0001;
        frame();
        pixel(20, 30, c_SKY, 3'b100, 1'b0);
        pixel(26, 39, c_SKY, 3'b100, 1'b0);
        pixel(27, 39, c_SKY, c_SKY, 1'b0);
        pixel(26, 40, c_SKY, c_SKY, 1'b0);
        pixel(19, 30, 3'b110, 3'b110, 1'b0);
        idle(4);

        // Overlapping sprites: priority and sprite-vs-sprite hit
        set_spr(0, 50, 50, 3'b100);
        set_spr(1, 50, 50, 3'b010);
        spr_en = 4'b0011;
        frame();
        pixel(52, 52, c_SKY, 3'b100, 1'b0);
        idle(4);
        check("overlap_hit_spr", 32'(hit_spr), 32'd1);
        check("overlap_hit_bg", 32'(hit_bg), 32'd0);

        // Sprite over non-sky background
        set_spr(2, 60, 60, 3'b001);
        spr_en = 4'b0100;
        frame();
        check("frame_clears_spr", 32'(hit_spr), 32'd0);
        pixel(61, 61, 3'b010, 3'b001, 1'b1);
        idle(4);
        check("bg_hit_bg", 32'(hit_bg), 32'h4);
        check("bg_hit_spr", 32'(hit_spr), 32'd0);
        frame();
        check("frame_clears_bg", 32'(hit_bg), 32'd0);

        // Staged change without frame_start must not move the sprite
        set_spr(2, 100, 60, 3'b001);
        pixel(61, 61, c_SKY, 3'b001, 1'b0);
        pixel(101, 61, c_SKY, c_SKY, 1'b0);
        frame();
        pixel(61, 61, c_SKY, c_SKY, 1'b0);
        pixel(101, 61, c_SKY, 3'b001, 1'b0);

        // Right-edge clipping, disabled sprite covering the origin
        set_spr(0, 252, 0, 3'b110);
        set_spr(1, 0, 0, 3'b111);
        spr_en = 4'b0001;
        frame();
        pixel(255, 5, 3'b101, 3'b110, 1'b1);
        pixel(0, 5, c_SKY, c_SKY, 1'b0);
        pixel(251, 5, c_SKY, c_SKY, 1'b0);
        pixel(252, 9, c_SKY, 3'b110, 1'b0);
        pixel(252, 10, c_SKY, c_SKY, 1'b0);
        idle(4);
        check("clip_hit_bg", 32'(hit_bg), 32'h1);

        // Reset with a pixel in stage 1 flushes it
        step();
        pix_valid = 1'b1;
        x = 8'd253; y = 7'd5; in_colour = 3'b101;
        step();
        pix_valid = 1'b0;
        reset = 1'b1;
        step();
        #1;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_hits", {hit_bg, hit_spr, hit_now}, 32'd0);
        check("rst_mid_colour", 32'(out_colour), 32'(c_SKY));
        reset = 1'b0;
        // Active registers were cleared, so nothing draws until the next frame_start
        pixel(253, 5, c_SKY, c_SKY, 1'b0);
        idle(4);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
